// File: rtl/sha_pkg.sv
// Shared word-level definitions for the subtractor pipeline.
// WORD_WIDTH is the default operand width; word_t is the matching word type.
package sha_pkg;

  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage : sha_pkg

// File: rtl/borrow_select_sub_half.sv
// Combinational half-width subtractor: o_diff = i_a - i_b - i_borrow.
// Both candidate results (borrow-in 0 and borrow-in 1) are formed in
// parallel, and the incoming borrow only drives the final select. This
// keeps the borrow-in off the long subtract chain.
module borrow_select_sub_half #(
  parameter int HALF_WIDTH = 16
) (
  input  logic [HALF_WIDTH-1:0] i_a,
  input  logic [HALF_WIDTH-1:0] i_b,
  input  logic                  i_borrow,
  output logic [HALF_WIDTH-1:0] o_diff,
  output logic                  o_borrow
);

  // One extra MSB per candidate: after the subtract it holds the borrow out,
  // because a negative result in HALF_WIDTH+1 bits sets the top bit.
  logic [HALF_WIDTH:0] w_diff_b0;
  logic [HALF_WIDTH:0] w_diff_b1;

  assign w_diff_b0 = {1'b0, i_a} - {1'b0, i_b};
  assign w_diff_b1 = {1'b0, i_a} - {1'b0, i_b} - {{HALF_WIDTH{1'b0}}, 1'b1};

  assign o_diff   = i_borrow ? w_diff_b1[HALF_WIDTH-1:0] : w_diff_b0[HALF_WIDTH-1:0];
  assign o_borrow = i_borrow ? w_diff_b1[HALF_WIDTH]     : w_diff_b0[HALF_WIDTH];

endmodule : borrow_select_sub_half

// File: rtl/sub_32b_pipe.sv
// Two-stage pipelined subtractor with valid/ready handshakes on both sides.
//   S1: low-half difference, low-half borrow, registered high-half operands.
//   S2: full difference (and the final borrow when enabled).
// Latency is 2 cycles from input transfer to o_valid; throughput is 1/cycle.
// Optional feature: define SUB_BORROW_OUT_EN to add the o_borrow output
// (unsigned i_a < i_b) and its S2 register. Without it the port and the
// register are absent and everything else is unchanged.
// WIDTH must be even and at least 8.
module sub_32b_pipe
  import sha_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_valid,
  input  logic             i_ready
`ifdef SUB_BORROW_OUT_EN
  ,
  output logic             o_borrow
`endif
);

  localparam int HALF = WIDTH / 2;

  // Stage 1 state
  logic            r_s1_valid;
  logic [HALF-1:0] r_s1_diff_lo;
  logic            r_s1_borrow_lo;
  logic [HALF-1:0] r_s1_a_hi;
  logic [HALF-1:0] r_s1_b_hi;

  // Stage 2 state
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_diff;
`ifdef SUB_BORROW_OUT_EN
  logic             r_s2_borrow;
`endif

  // Combinational nets
  logic [HALF-1:0] w_lo_diff;
  logic            w_lo_borrow;
  logic [HALF-1:0] w_hi_diff;
`ifdef SUB_BORROW_OUT_EN
  logic            w_hi_borrow;
`else
  // The high-half borrow has no consumer when the borrow output is disabled.
  logic            w_unused_hi_borrow;
`endif
  logic            w_s2_load;
  logic            w_in_xfer;

  // S2 accepts new data when it is empty or its result leaves this cycle.
  assign w_s2_load = !r_s2_valid || i_ready;

  // S1 can take an operand pair when it is empty or it moves into S2 this
  // cycle. Depends only on state and i_ready, never on i_valid.
  assign o_ready   = !r_s1_valid || w_s2_load;
  assign w_in_xfer = i_valid && o_ready;

  // Low half: plain subtract, no borrow in.
  borrow_select_sub_half #(
    .HALF_WIDTH(HALF)
  ) u_sub_lo (
    .i_a     (i_a[HALF-1:0]),
    .i_b     (i_b[HALF-1:0]),
    .i_borrow(1'b0),
    .o_diff  (w_lo_diff),
    .o_borrow(w_lo_borrow)
  );

  // High half: uses the operands and low borrow captured in S1.
  borrow_select_sub_half #(
    .HALF_WIDTH(HALF)
  ) u_sub_hi (
    .i_a     (r_s1_a_hi),
    .i_b     (r_s1_b_hi),
    .i_borrow(r_s1_borrow_lo),
    .o_diff  (w_hi_diff),
`ifdef SUB_BORROW_OUT_EN
    .o_borrow(w_hi_borrow)
`else
    .o_borrow(w_unused_hi_borrow)
`endif
  );

  // Stage 1 register: capture the low-half result and high-half operands on
  // input transfer; drain to empty when S1 advances without a new pair.
  always_ff @(posedge i_clk) begin
    // NOTE: datapath registers are reset along with the valid flags so that
    // o_diff reads 0 after reset and no stale operand survives a flush.
    if (i_rst) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so the two stages shift together without races.
      r_s1_valid     <= 1'b0;
      r_s1_diff_lo   <= '0;
      r_s1_borrow_lo <= 1'b0;
      r_s1_a_hi      <= '0;
      r_s1_b_hi      <= '0;
    end else if (o_ready) begin
      r_s1_valid <= i_valid;
      if (w_in_xfer) begin
        r_s1_diff_lo   <= w_lo_diff;
        r_s1_borrow_lo <= w_lo_borrow;
        r_s1_a_hi      <= i_a[WIDTH-1:HALF];
        r_s1_b_hi      <= i_b[WIDTH-1:HALF];
      end
    end
  end

  // Stage 2 register: assemble the full difference from S1; hold it stable
  // while the downstream stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_diff   <= '0;
`ifdef SUB_BORROW_OUT_EN
      r_s2_borrow <= 1'b0;
`endif
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_diff   <= {w_hi_diff, r_s1_diff_lo};
`ifdef SUB_BORROW_OUT_EN
        r_s2_borrow <= w_hi_borrow;
`endif
      end
    end
  end

  assign o_valid  = r_s2_valid;
  assign o_diff   = r_s2_diff;
`ifdef SUB_BORROW_OUT_EN
  assign o_borrow = r_s2_borrow;
`endif

endmodule : sub_32b_pipe
